// File: rtl/can_txmb_pkg.sv
// can_txmb_pkg: shared types and helpers for the CAN transmit mailbox block.
//   mb_state_t  - per-mailbox lifecycle (EMPTY -> LOADED -> PENDING -> ACTIVE)
//   arb_state_t - transmit arbiter states (IDLE -> OFFER -> INFLIGHT)
//   MAX_BYTES   - classic CAN payload limit
//   dlc_clamp   - DLC to number of payload bytes actually carried
package can_txmb_pkg;

    typedef enum logic [1:0] {
        MB_EMPTY   = 2'd0,
        MB_LOADED  = 2'd1,
        MB_PENDING = 2'd2,
        MB_ACTIVE  = 2'd3
    } mb_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_OFFER    = 2'd1,
        ARB_INFLIGHT = 2'd2
    } arb_state_t;

    localparam int MAX_BYTES = 8;

    // DLC codes 9..15 still mean 8 bytes on a classic CAN frame.
    function automatic logic [3:0] dlc_clamp(input logic [3:0] dlc);
        return (dlc > 4'd8) ? 4'd8 : dlc;
    endfunction

endpackage

// File: rtl/can_txmb_arb.sv
// can_txmb_arb: combinational picker over the pending mailboxes.
//   pend  - NUM_MB flags, mailbox is PENDING
//   ids   - identifier of each mailbox
//   found - at least one mailbox pending
//   win   - lowest identifier wins; equal identifiers go to the lowest index
module can_txmb_arb #(
    parameter int NUM_MB = 4,
    parameter int ID_W   = 11,
    parameter int MBW    = 2
) (
    input  logic [NUM_MB-1:0]           pend,
    input  logic [NUM_MB-1:0][ID_W-1:0] ids,
    output logic                        found,
    output logic [MBW-1:0]              win
);

    logic [ID_W-1:0] best;

    always_comb begin
        found = 1'b0;
        win   = '0;
        best  = '0;
        // Strict '<' keeps the earlier (lower) index on an identifier tie.
        for (int i = 0; i < NUM_MB; i++) begin
            if (pend[i] && (!found || ids[i] < best)) begin
                found = 1'b1;
                win   = MBW'(i);
                best  = ids[i];
            end
        end
    end

endmodule

// File: rtl/can_tx_mbox.sv
// can_tx_mbox: NUM_MB transmit mailboxes feeding one CAN frame generator.
//   Host side : wr_mb selects the mailbox for hdr_wr / data_wr / commit / abort.
//   Generator : fg_valid/fg_ready offer handshake with fg_mb/id/rtr/dlc/data,
//               then tx_success / tx_fail report the outcome of the frame.
//   Status    : mb_busy (not EMPTY), tx_done / tx_err one-cycle pulses, all_full.
// Optional build macro CAN_TXMB_RETRY_LIMIT_EN: drop a mailbox after RETRY_MAX
// consecutive tx_fail events; without it retries are unlimited.
module can_tx_mbox
    import can_txmb_pkg::*;
#(
    parameter int NUM_MB    = 4,
    parameter int ID_W      = 11,
    parameter int RETRY_MAX = 8
) (
    input  logic                      clk,
    input  logic                      g_rst,
    input  logic [$clog2(NUM_MB)-1:0] wr_mb,
    input  logic                      hdr_wr,
    input  logic [ID_W-1:0]           hdr_id,
    input  logic                      hdr_rtr,
    input  logic [3:0]                hdr_dlc,
    input  logic                      data_wr,
    input  logic [2:0]                data_idx,
    input  logic [7:0]                data_byte,
    input  logic                      commit,
    input  logic                      abort,
    output logic                      fg_valid,
    input  logic                      fg_ready,
    output logic [$clog2(NUM_MB)-1:0] fg_mb,
    output logic [ID_W-1:0]           fg_id,
    output logic                      fg_rtr,
    output logic [3:0]                fg_dlc,
    output logic [63:0]               fg_data,
    input  logic                      tx_success,
    input  logic                      tx_fail,
    output logic [NUM_MB-1:0]         mb_busy,
    output logic [NUM_MB-1:0]         tx_done,
    output logic [NUM_MB-1:0]         tx_err,
    output logic                      all_full
);

    localparam int MBW = $clog2(NUM_MB);

    mb_state_t                          mb_st [NUM_MB];
    logic [NUM_MB-1:0][ID_W-1:0]        mb_id;
    logic [NUM_MB-1:0]                  mb_rtr;
    logic [NUM_MB-1:0][3:0]             mb_dlc;
    logic [NUM_MB-1:0][MAX_BYTES-1:0][7:0] mb_data;

    arb_state_t arb_st, arb_nx;
    logic       pick_vld;
    logic [MBW-1:0] pick_idx;
    logic       arb_found;
    logic [MBW-1:0] arb_win;
    logic       abort_pend;

    logic [NUM_MB-1:0] sel, off_sel, pend, retry_last;
    logic pick_ok, go_offer, hs, ab_hit, withdraw, succ, fail, kill;

    logic [ID_W-1:0]              nx_id;
    logic                         nx_rtr;
    logic [3:0]                   nx_dlc;
    logic [MAX_BYTES-1:0][7:0]    nx_data;

    // Per-mailbox decode plus the frame image of the registered pick.
    always_comb begin
        sel     = '0;
        off_sel = '0;
        pend    = '0;
        pick_ok = 1'b0;
        nx_id   = '0;
        nx_rtr  = 1'b0;
        nx_dlc  = '0;
        nx_data = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            sel[i]     = (wr_mb == MBW'(i));
            off_sel[i] = (fg_mb == MBW'(i));
            pend[i]    = (mb_st[i] == MB_PENDING);
            if (pick_idx == MBW'(i)) begin
                // The pick is one cycle old: it may have been aborted since.
                pick_ok = pend[i] && !(abort && sel[i]);
                nx_id   = mb_id[i];
                nx_rtr  = mb_rtr[i];
                nx_dlc  = mb_dlc[i];
                for (int b = 0; b < MAX_BYTES; b++)
                    if (!mb_rtr[i] && b < int'(dlc_clamp(mb_dlc[i])))
                        nx_data[b] = mb_data[i][b];
            end
        end
    end

    can_txmb_arb #(.NUM_MB(NUM_MB), .ID_W(ID_W), .MBW(MBW)) u_arb (
        .pend  (pend),
        .ids   (mb_id),
        .found (arb_found),
        .win   (arb_win)
    );

    assign ab_hit   = abort && (wr_mb == fg_mb);
    assign hs       = (arb_st == ARB_OFFER) && fg_ready;
    assign withdraw = (arb_st == ARB_OFFER) && !fg_ready && ab_hit;
    assign succ     = (arb_st == ARB_INFLIGHT) && tx_success;
    assign fail     = (arb_st == ARB_INFLIGHT) && tx_fail && !tx_success;
    assign kill     = abort_pend || ((arb_st == ARB_INFLIGHT) && ab_hit);
    assign go_offer = (arb_st == ARB_IDLE) && pick_vld && pick_ok;

    assign fg_valid = (arb_st == ARB_OFFER);
    assign all_full = &mb_busy;

    always_comb begin
        for (int i = 0; i < NUM_MB; i++)
            mb_busy[i] = (mb_st[i] != MB_EMPTY);
    end

    // Arbiter FSM
    always_comb begin
        arb_nx = arb_st;
        case (arb_st)
            ARB_IDLE:     if (go_offer) arb_nx = ARB_OFFER;
            ARB_OFFER:    if (hs) arb_nx = ARB_INFLIGHT;
                          else if (withdraw) arb_nx = ARB_IDLE;
            ARB_INFLIGHT: if (succ || fail) arb_nx = ARB_IDLE;
            default:      arb_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            arb_st     <= ARB_IDLE;
            pick_vld   <= 1'b0;
            pick_idx   <= '0;
            abort_pend <= 1'b0;
            fg_mb      <= '0;
            fg_id      <= '0;
            fg_rtr     <= 1'b0;
            fg_dlc     <= '0;
            fg_data    <= '0;
        end else begin
            arb_st   <= arb_nx;
            pick_vld <= arb_found;
            pick_idx <= arb_win;
            // Offer image is frozen here; mailbox writes are locked out until completion.
            if (go_offer) begin
                fg_mb   <= pick_idx;
                fg_id   <= nx_id;
                fg_rtr  <= nx_rtr;
                fg_dlc  <= nx_dlc;
                fg_data <= nx_data;
            end
            if (succ || fail)
                abort_pend <= 1'b0;
            else if (ab_hit && (hs || arb_st == ARB_INFLIGHT))
                abort_pend <= 1'b1;
        end
    end

    // Mailbox storage and lifecycle
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            for (int i = 0; i < NUM_MB; i++) mb_st[i] <= MB_EMPTY;
            mb_id   <= '0;
            mb_rtr  <= '0;
            mb_dlc  <= '0;
            mb_data <= '0;
            tx_done <= '0;
            tx_err  <= '0;
        end else begin
            tx_done <= '0;
            tx_err  <= '0;
            for (int i = 0; i < NUM_MB; i++) begin
                if (sel[i] && (mb_st[i] == MB_EMPTY || mb_st[i] == MB_LOADED)) begin
                    if (hdr_wr) begin
                        mb_id[i]  <= hdr_id;
                        mb_rtr[i] <= hdr_rtr;
                        mb_dlc[i] <= hdr_dlc;
                    end
                    if (data_wr) mb_data[i][data_idx] <= data_byte;
                end
                // Completion and handoff outrank host actions; abort outranks commit.
                if (off_sel[i] && succ) begin
                    mb_st[i]   <= MB_EMPTY;
                    tx_done[i] <= 1'b1;
                end else if (off_sel[i] && fail) begin
                    if (kill || retry_last[i]) begin
                        mb_st[i]  <= MB_EMPTY;
                        tx_err[i] <= 1'b1;
                    end else begin
                        mb_st[i] <= MB_PENDING;
                    end
                end else if (off_sel[i] && hs) begin
                    mb_st[i] <= MB_ACTIVE;
                end else if (sel[i] && abort &&
                             (mb_st[i] == MB_LOADED || mb_st[i] == MB_PENDING)) begin
                    mb_st[i]  <= MB_EMPTY;
                    tx_err[i] <= 1'b1;
                end else if (sel[i] && commit && mb_st[i] == MB_LOADED) begin
                    mb_st[i] <= MB_PENDING;
                end else if (sel[i] && hdr_wr && mb_st[i] == MB_EMPTY) begin
                    mb_st[i] <= MB_LOADED;
                end
            end
        end
    end

`ifdef CAN_TXMB_RETRY_LIMIT_EN
    localparam int RC_W = $clog2(RETRY_MAX + 1);
    logic [NUM_MB-1:0][RC_W-1:0] retry_cnt;

    always_comb begin
        for (int i = 0; i < NUM_MB; i++)
            retry_last[i] = (retry_cnt[i] == RC_W'(RETRY_MAX - 1));
    end

    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            retry_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_MB; i++) begin
                if (sel[i] && commit && !abort && mb_st[i] == MB_LOADED)
                    retry_cnt[i] <= '0;
                else if (off_sel[i] && fail)
                    retry_cnt[i] <= retry_last[i] ? '0 : retry_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign retry_last = '0;
`endif

endmodule

// File: tb/tb_can_tx_mbox.sv
module tb_can_tx_mbox;
    localparam int NUM_MB = 4;
    localparam int ID_W   = 11;
`ifdef CAN_TXMB_RETRY_LIMIT_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic g_rst = 1'b1;
    logic [1:0] wr_mb;
    logic hdr_wr, hdr_rtr, data_wr, commit, abort, fg_ready, tx_success, tx_fail;
    logic [ID_W-1:0] hdr_id;
    logic [3:0] hdr_dlc;
    logic [2:0] data_idx;
    logic [7:0] data_byte;
    logic fg_valid, fg_rtr, all_full;
    logic [1:0] fg_mb;
    logic [ID_W-1:0] fg_id;
    logic [3:0] fg_dlc;
    logic [63:0] fg_data;
    logic [3:0] mb_busy, tx_done, tx_err;

    int checks = 0;
    int errors = 0;

    // Reference model: what the host last wrote into each mailbox.
    logic [ID_W-1:0] m_id   [4];
    logic            m_rtr  [4];
    logic [3:0]      m_dlc  [4];
    logic [63:0]     m_data [4];

    always #5 clk = ~clk;

    can_tx_mbox #(.NUM_MB(NUM_MB), .ID_W(ID_W), .RETRY_MAX(3)) dut (
        .clk(clk), .g_rst(g_rst), .wr_mb(wr_mb), .hdr_wr(hdr_wr), .hdr_id(hdr_id),
        .hdr_rtr(hdr_rtr), .hdr_dlc(hdr_dlc), .data_wr(data_wr), .data_idx(data_idx),
        .data_byte(data_byte), .commit(commit), .abort(abort), .fg_valid(fg_valid),
        .fg_ready(fg_ready), .fg_mb(fg_mb), .fg_id(fg_id), .fg_rtr(fg_rtr),
        .fg_dlc(fg_dlc), .fg_data(fg_data), .tx_success(tx_success), .tx_fail(tx_fail),
        .mb_busy(mb_busy), .tx_done(tx_done), .tx_err(tx_err), .all_full(all_full)
    );

    // Payload as it must appear on the wire: min(DLC,8) bytes, none for RTR.
    function automatic logic [63:0] exp_payload(input int mb);
        int n;
        logic [63:0] v;
        v = 64'd0;
        if (m_rtr[mb]) return v;
        n = (m_dlc[mb] > 4'd8) ? 8 : int'(m_dlc[mb]);
        for (int b = 0; b < n; b++) v[8*b +: 8] = m_data[mb][8*b +: 8];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_mb = 0; hdr_wr = 0; hdr_id = 0; hdr_rtr = 0; hdr_dlc = 0;
        data_wr = 0; data_idx = 0; data_byte = 0; commit = 0; abort = 0;
        fg_ready = 0; tx_success = 0; tx_fail = 0;
    endtask

    task automatic load(input int mb, input logic [ID_W-1:0] id, input logic rtr,
                        input logic [3:0] dlc, input logic [63:0] data);
        m_id[mb] = id; m_rtr[mb] = rtr; m_dlc[mb] = dlc; m_data[mb] = data;
        wr_mb = 2'(mb); hdr_wr = 1; hdr_id = id; hdr_rtr = rtr; hdr_dlc = dlc;
        tick();
        hdr_wr = 0;
        for (int b = 0; b < 8; b++) begin
            data_wr = 1; data_idx = 3'(b); data_byte = data[8*b +: 8];
            tick();
        end
        data_wr = 0;
    endtask

    task automatic do_commit(input int mb);
        wr_mb = 2'(mb); commit = 1;
        tick();
        commit = 0;
    endtask

    task automatic wait_valid(output bit got);
        got = 0;
        for (int k = 0; k < 30; k++) begin
            if (fg_valid === 1'b1) begin
                got = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic accept();
        fg_ready = 1;
        tick();
        fg_ready = 0;
    endtask

    task automatic finish_tx(input bit ok);
        tx_success = ok; tx_fail = !ok;
        tick();
        tx_success = 0; tx_fail = 0;
    endtask

    task automatic test_reset();
        checks++; if (fg_valid !== 1'b0) begin errors++; $display("FAIL reset_fg_valid got %b want 0", fg_valid); end
        checks++; if (mb_busy !== 4'b0) begin errors++; $display("FAIL reset_mb_busy got %b want 0000", mb_busy); end
        checks++; if ({tx_done, tx_err} !== 8'b0) begin errors++; $display("FAIL reset_pulses got %b want 0", {tx_done, tx_err}); end
        checks++; if ({all_full, fg_data} !== 65'b0) begin errors++; $display("FAIL reset_data got %h want 0", {all_full, fg_data}); end
    endtask

    task automatic test_basic();
        bit got;
        logic [63:0] d, hold;
        d = {$urandom, $urandom};
        d[15:0] = 16'hBBAA;
        load(0, 11'h123, 1'b0, 4'd2, d);
        do_commit(0);
        checks++; if (fg_valid !== 1'b0) begin errors++; $display("FAIL basic_lat0 got %b want 0", fg_valid); end
        tick();
        checks++; if (fg_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1 got %b want 0", fg_valid); end
        tick();
        checks++; if (fg_valid !== 1'b1) begin errors++; $display("FAIL basic_lat2 got %b want 1", fg_valid); end
        checks++; if ({fg_mb, fg_id, fg_dlc} !== {2'd0, 11'h123, 4'd2}) begin errors++; $display("FAIL basic_hdr got %h/%h/%h want 0/123/2", fg_mb, fg_id, fg_dlc); end
        checks++; if (fg_data !== 64'hBBAA) begin errors++; $display("FAIL basic_data got %h want %h", fg_data, 64'hBBAA); end
        hold = fg_data;
        for (int k = 0; k < 3; k++) tick();
        checks++; if ({fg_valid, fg_data, fg_id} !== {1'b1, hold, 11'h123}) begin errors++; $display("FAIL basic_stable got %b/%h want 1/%h", fg_valid, fg_data, hold); end
        accept();
        checks++; if ({fg_valid, mb_busy[0]} !== 2'b01) begin errors++; $display("FAIL basic_handoff got %b want 01", {fg_valid, mb_busy[0]}); end
        finish_tx(1);
        checks++; if ({tx_done, tx_err, mb_busy} !== 12'b0001_0000_0000) begin errors++; $display("FAIL basic_done got %b want 000100000000", {tx_done, tx_err, mb_busy}); end
        tick();
        checks++; if (tx_done !== 4'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0000", tx_done); end
        wait_valid(got);
        checks++; if (got) begin errors++; $display("FAIL basic_no_reoffer got %b want 0", got); end
    endtask

    task automatic test_arbitration();
        bit got;
        int keys[$];
        int e;
        logic [ID_W-1:0] id;
        for (int it = 0; it < 5; it++) begin
            // mb0 is held in OFFER so mb1..3 become pending together.
            load(0, ID_W'($urandom), 1'b0, 4'($urandom_range(0, 8)), {$urandom, $urandom});
            do_commit(0);
            wait_valid(got);
            checks++; if (!got || fg_mb !== 2'd0) begin errors++; $display("FAIL arb_blocker got %b/%0d want 1/0", got, fg_mb); end
            keys.delete();
            for (int mb = 1; mb < 4; mb++) begin
                if (it == 0) id = (mb == 1) ? 11'h200 : 11'h100;
                else id = ID_W'($urandom_range(0, 3) * 16);
                load(mb, id, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), {$urandom, $urandom});
                do_commit(mb);
                keys.push_back(int'(id) * NUM_MB + mb);
            end
            checks++; if (all_full !== 1'b1) begin errors++; $display("FAIL arb_all_full got %b want 1", all_full); end
            accept();
            finish_tx(1);
            keys.sort();
            foreach (keys[k]) begin
                e = keys[k] % NUM_MB;
                wait_valid(got);
                checks++; if (!got || fg_mb !== 2'(e)) begin errors++; $display("FAIL arb_order it%0d got %b/%0d want 1/%0d", it, got, fg_mb, e); end
                checks++; if ({fg_id, fg_rtr, fg_dlc, fg_data} !== {m_id[e], m_rtr[e], m_dlc[e], exp_payload(e)})
                    begin errors++; $display("FAIL arb_frame mb%0d got %h/%b/%h/%h want %h/%b/%h/%h", e, fg_id, fg_rtr, fg_dlc, fg_data, m_id[e], m_rtr[e], m_dlc[e], exp_payload(e)); end
                accept();
                finish_tx(1);
                checks++; if (tx_done !== 4'(1 << e)) begin errors++; $display("FAIL arb_done got %b want %b", tx_done, 4'(1 << e)); end
            end
        end
    endtask

    task automatic test_retry_reoffer();
        bit got;
        load(0, 11'h300, 1'b0, 4'd8, {$urandom, $urandom});
        do_commit(0);
        wait_valid(got);
        accept();
        // Writes to an ACTIVE mailbox must not reach its storage.
        wr_mb = 0; hdr_wr = 1; hdr_id = 11'h001; data_wr = 1; data_idx = 0; data_byte = ~m_data[0][7:0];
        tick();
        hdr_wr = 0; data_wr = 0;
        load(1, 11'h050, 1'b0, 4'd3, {$urandom, $urandom});
        do_commit(1);
        finish_tx(0);
        checks++; if ({tx_err, tx_done, mb_busy[0]} !== 9'b0000_0000_1) begin errors++; $display("FAIL retry_fail got %b want 000000001", {tx_err, tx_done, mb_busy[0]}); end
        wait_valid(got);
        checks++; if (!got || fg_mb !== 2'd1) begin errors++; $display("FAIL retry_order got %b/%0d want 1/1", got, fg_mb); end
        accept();
        finish_tx(1);
        wait_valid(got);
        checks++; if (!got || {fg_mb, fg_id, fg_data} !== {2'd0, 11'h300, exp_payload(0)}) begin errors++; $display("FAIL retry_reoffer got %b/%0d/%h/%h want 1/0/300/%h", got, fg_mb, fg_id, fg_data, exp_payload(0)); end
        accept();
        finish_tx(1);
        checks++; if (tx_done !== 4'b0001) begin errors++; $display("FAIL retry_done got %b want 0001", tx_done); end
    endtask

    task automatic test_abort();
        bit got;
        load(2, ID_W'($urandom), 1'b0, 4'd4, {$urandom, $urandom});
        do_commit(2);
        wait_valid(got);
        wr_mb = 2; abort = 1; fg_ready = 0;
        tick();
        abort = 0;
        checks++; if ({fg_valid, tx_err, mb_busy[2]} !== 6'b0_0100_0) begin errors++; $display("FAIL abort_withdraw got %b want 001000", {fg_valid, tx_err, mb_busy[2]}); end
        wait_valid(got);
        checks++; if (got) begin errors++; $display("FAIL abort_withdraw_reoffer got %b want 0", got); end
        load(3, ID_W'($urandom), 1'b0, 4'd1, {$urandom, $urandom});
        do_commit(3);
        wait_valid(got);
        wr_mb = 3; abort = 1; fg_ready = 1;
        tick();
        abort = 0; fg_ready = 0;
        checks++; if ({fg_valid, tx_err, mb_busy[3]} !== 6'b0_0000_1) begin errors++; $display("FAIL abort_handoff got %b want 000001", {fg_valid, tx_err, mb_busy[3]}); end
        finish_tx(0);
        checks++; if ({tx_err, mb_busy[3]} !== 5'b1000_0) begin errors++; $display("FAIL abort_latched got %b want 10000", {tx_err, mb_busy[3]}); end
        wait_valid(got);
        checks++; if (got) begin errors++; $display("FAIL abort_no_retry got %b want 0", got); end
        load(1, ID_W'($urandom), 1'b0, 4'd2, {$urandom, $urandom});
        wr_mb = 1; commit = 1; abort = 1;
        tick();
        commit = 0;
        checks++; if ({tx_err, mb_busy} !== 8'b0010_0000) begin errors++; $display("FAIL abort_vs_commit got %b want 00100000", {tx_err, mb_busy}); end
        tick();
        abort = 0;
        checks++; if ({tx_err, mb_busy} !== 8'b0) begin errors++; $display("FAIL abort_empty got %b want 0", {tx_err, mb_busy}); end
        wait_valid(got);
        checks++; if (got) begin errors++; $display("FAIL abort_commit_reoffer got %b want 0", got); end
    endtask

    task automatic test_rtr_retry();
        bit got;
        bit dropped;
        logic [3:0] want_err;
        load(1, 11'h0AA, 1'b1, 4'd15, {$urandom | 32'h1, $urandom | 32'h1});
        do_commit(1);
        wait_valid(got);
        checks++; if (!got || {fg_rtr, fg_dlc, fg_data} !== {1'b1, 4'd15, 64'd0}) begin errors++; $display("FAIL rtr_frame got %b/%h/%h want 1/f/0", fg_rtr, fg_dlc, fg_data); end
        accept();
        dropped = 0;
        for (int f = 0; f < 3; f++) begin
            finish_tx(0);
            want_err = (RETRY_EN && f == 2) ? 4'b0010 : 4'b0000;
            checks++; if (tx_err !== want_err) begin errors++; $display("FAIL retry_limit f%0d got %b want %b", f, tx_err, want_err); end
            checks++; if (mb_busy[1] !== !(RETRY_EN && f == 2)) begin errors++; $display("FAIL retry_busy f%0d got %b want %b", f, mb_busy[1], !(RETRY_EN && f == 2)); end
            dropped = (RETRY_EN && f == 2);
            if (!dropped) begin
                wait_valid(got);
                checks++; if (!got || fg_mb !== 2'd1) begin errors++; $display("FAIL retry_reoffer f%0d got %b/%0d want 1/1", f, got, fg_mb); end
                if (f == 2) begin
                    accept();
                    finish_tx(1);
                    checks++; if (tx_done !== 4'b0010) begin errors++; $display("FAIL retry_unlimited got %b want 0010", tx_done); end
                end else begin
                    accept();
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        bit got;
        load(0, ID_W'($urandom), 1'b0, 4'd8, {$urandom, $urandom});
        do_commit(0);
        wait_valid(got);
        accept();
        tx_success = 1;
        #2 g_rst = 1;
        #1;
        checks++; if ({fg_valid, mb_busy, tx_done, tx_err, all_full} !== 14'b0) begin errors++; $display("FAIL rst_outputs got %b want 0", {fg_valid, mb_busy, tx_done, tx_err, all_full}); end
        checks++; if ({fg_mb, fg_id, fg_rtr, fg_dlc, fg_data} !== '0) begin errors++; $display("FAIL rst_fg got %h/%h/%h want 0", fg_id, fg_dlc, fg_data); end
        tick();
        tx_success = 0;
        g_rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({tx_done, tx_err, mb_busy, fg_valid} !== 13'b0) begin errors++; $display("FAIL rst_no_pulse got %b want 0", {tx_done, tx_err, mb_busy, fg_valid}); end
        end
    endtask

    initial begin
        idle_in();
        tick();
        tick();
        g_rst = 0;
        tick();
        test_reset();
        test_basic();
        test_arbitration();
        test_retry_reoffer();
        test_abort();
        test_rtr_retry();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
